// File: rtl/processor_datapath.sv
// Bus-centred 10-bit datapath: four general registers, ALU operand registers A/G,
// instruction register and a 2-bit step counter driven by an external controller.
module processor_datapath (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] data_in,
  input  logic [9:0] IMM,
  input  logic [1:0] Rin,
  input  logic [1:0] Rout,
  input  logic       ENW,
  input  logic       ENR,
  input  logic       Ain,
  input  logic       Gin,
  input  logic       Gout,
  input  logic [3:0] ALUcont,
  input  logic       Ext,
  input  logic       IRin,
  input  logic       Clr,
  output logic [9:0] IR,
  output logic [1:0] timestep,
  output logic [9:0] bus,
  output logic       done,
  output logic       bus_conflict
);

  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_NOT  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_NAND = 4'b1000;
  localparam logic [3:0] OP_NOR  = 4'b1001;
  localparam logic [3:0] OP_XNOR = 4'b1010;
  localparam logic [3:0] OP_SHL  = 4'b1011;

  logic [9:0] regs_r [4];
  logic [9:0] a_r;
  logic [9:0] g_r;
  logic [9:0] ir_r;
  logic [1:0] ts_r;
  logic       done_r;
  logic       conflict_r;
  logic [9:0] bus_s;
  logic       multi_drv_s;

  // Shift amounts of 10 or more push every bit out of the 10-bit word.
  function automatic logic [9:0] alu_f(input logic [3:0] op, input logic [9:0] a,
                                       input logic [9:0] g);
    logic [9:0] res;
    res = 10'd0;
    case (op)
      OP_ADD:  res = a + g;
      OP_SUB:  res = a - g;
      OP_NOT:  res = ~a;
      OP_AND:  res = a & g;
      OP_OR:   res = a | g;
      OP_XOR:  res = a ^ g;
      OP_NAND: res = ~(a & g);
      OP_NOR:  res = ~(a | g);
      OP_XNOR: res = ~(a ^ g);
      OP_SHL: begin
        if (g[3:0] >= 4'd10) begin
          res = 10'd0;
        end else begin
          res = a << g[3:0];
        end
      end
      default: res = 10'd0;
    endcase
    return res;
  endfunction

  // Bus source select; IMM and ALUcont are only looked at when actually selected.
  always_comb begin
    bus_s = 10'd0;
    if (Ext) begin
      bus_s = data_in;
    end else if (Gout) begin
      bus_s = alu_f(ALUcont, a_r, g_r);
    end else if (ENR) begin
      bus_s = regs_r[Rout];
    end else begin
      bus_s = IMM;
    end
  end

  assign multi_drv_s = (Ext & Gout) | (Ext & ENR) | (Gout & ENR);

  // Register file and operand/instruction registers all sample the same bus value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        regs_r[i] <= 10'd0;
      end
      a_r  <= 10'd0;
      g_r  <= 10'd0;
      ir_r <= 10'd0;
    end else begin
      if (ENW)  regs_r[Rin] <= bus_s;
      if (Ain)  a_r         <= bus_s;
      if (Gin)  g_r         <= bus_s;
      if (IRin) ir_r        <= bus_s;
    end
  end

  // Step counter, end-of-instruction pulse and sticky multi-driver flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_r       <= 2'd0;
      done_r     <= 1'b0;
      conflict_r <= 1'b0;
    end else begin
      ts_r       <= Clr ? 2'd0 : ts_r + 2'd1;
      done_r     <= Clr;
      conflict_r <= conflict_r | multi_drv_s;
    end
  end

  assign bus          = bus_s;
  assign IR           = ir_r;
  assign timestep     = ts_r;
  assign done         = done_r;
  assign bus_conflict = conflict_r;

endmodule
